// File: rtl/avalon_st_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the Avalon-ST packet FIFO.
// The RAM word layout is {data, eop, sop}.
package avalon_st_fifo_pkg;

  localparam int SOP_BIT = 0;
  localparam int EOP_BIT = 1;
  localparam int META_W  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int addr_w,
                                        input int af_th, input int ae_th);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (clog2(depth) == addr_w) && (af_th <= depth) && (ae_th <= depth);
  endfunction

endpackage

// File: rtl/avalon_st_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register doubles as the FIFO's show-ahead output stage.
module avalon_st_fifo_ram #(
  parameter int WIDTH      = 44,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Parametrised Avalon-ST FIFO with SOP/EOP sideband, optional store-and-forward,
// registered almost-full/almost-empty flags and a synchronous clear.
module avalon_st_pkt_fifo
  import avalon_st_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 42,
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int PACKET_MODE     = 0,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int AW = ADDR_WIDTH;
  localparam int FW = ADDR_WIDTH + 1;
  localparam int RW = DATA_WIDTH + META_W;
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0] AF_LVL   = FW'(ALMOST_FULL_TH);
  localparam logic [FW-1:0] AE_LVL   = FW'(ALMOST_EMPTY_TH);

  if (!fifo_params_ok(DEPTH, ADDR_WIDTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_param_err
    $error("avalon_st_pkt_fifo: illegal DEPTH/ADDR_WIDTH/threshold parameters");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] ram_cnt, ram_cnt_nxt, fill_nxt, pkt_nxt, ram_pkts;
  logic [RW-1:0] wword, q;
  logic          accept, wr_en, xfer, load, eligible, inside_pkt, open_q;

  assign in_ready          = (fill_level != FULL_LVL);
  assign accept            = in_valid & in_ready;
  assign wr_en             = accept & ~clear;
  assign xfer              = out_valid & out_ready;
  assign wword             = {in_data, in_endofpacket, in_startofpacket};
  assign out_data          = q[RW-1:META_W];
  assign out_startofpacket = q[SOP_BIT];
  assign out_endofpacket   = q[EOP_BIT];

  // Mid-packet if the held beat lacks EOP, or the last beat to leave lacked it.
  assign inside_pkt = out_valid ? ~out_endofpacket : open_q;
  // Complete packets whose EOP is still in RAM (excludes one sitting in the output stage).
  assign ram_pkts   = pkt_count - FW'(out_valid & out_endofpacket);

  always_comb begin
    eligible = 1'b1;
    if (PACKET_MODE != 0)
      eligible = (ram_pkts != '0) | inside_pkt |
                 ((fill_level == FULL_LVL) & (pkt_count == '0));
  end

  assign load = (~out_valid | xfer) & (ram_cnt != '0) & eligible;

  always_comb begin
    fill_nxt    = fill_level + FW'(accept) - FW'(xfer);
    ram_cnt_nxt = ram_cnt + FW'(accept) - FW'(load);
    pkt_nxt     = pkt_count + FW'(accept & in_endofpacket) - FW'(xfer & out_endofpacket);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      fill_level   <= '0;
      pkt_count    <= '0;
      out_valid    <= 1'b0;
      open_q       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr + AW'(accept);
      rd_ptr       <= rd_ptr + AW'(load);
      ram_cnt      <= ram_cnt_nxt;
      fill_level   <= fill_nxt;
      pkt_count    <= pkt_nxt;
      out_valid    <= load | (out_valid & ~xfer);
      if (xfer) open_q <= ~out_endofpacket;
      almost_full  <= (fill_nxt >= AF_LVL);
      almost_empty <= (fill_nxt <= AE_LVL);
    end
  end

  avalon_st_fifo_ram #(.WIDTH(RW), .ADDR_WIDTH(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wword),
    .re    (load & ~clear),
    .raddr (rd_ptr),
    .rdata (q)
  );

endmodule
